// File: rtl/output_mems.sv
// Result buffer for the matrix-multiply datapath. The compute unit fills C by address,
// and the block then streams it row-major as an AXI-Stream master.
module output_mems #(
    parameter int OUTW = 28,
    parameter int M    = 7,
    parameter int N    = 9
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             res_wr_en,
    input  logic [$clog2(M*N)-1:0]           res_wr_addr,
    input  logic [OUTW-1:0]                  res_wr_data,
    input  logic                             res_done,
    output logic                             buffer_free,
    output logic [OUTW-1:0]                  AXIS_TDATA,
    output logic                             AXIS_TVALID,
    input  logic                             AXIS_TREADY,
    output logic                             AXIS_TLAST
);
    localparam int MN          = M * N;
    localparam int C_ADDR_BITS = $clog2(MN);
    localparam logic [C_ADDR_BITS-1:0] LAST_ADDR = C_ADDR_BITS'(MN - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [OUTW-1:0]        r_mem [MN];
    logic [C_ADDR_BITS-1:0] r_rd_ptr, r_beat_cnt;
    logic                   r_rd_all;
    logic [OUTW-1:0]        r_rd_data, r_skid_data;
    logic                   r_rd_vld, r_rd_last, r_skid_vld, r_skid_last;
    logic                   w_pop, w_last_pop, w_issue, w_shift, w_wr;

    assign w_pop      = AXIS_TVALID && AXIS_TREADY;
    assign w_last_pop = w_pop && (r_beat_cnt == LAST_ADDR);
    // Skid can only be full while the read register also holds a beat, so the
    // two-entry buffer is full exactly when the skid is valid and not draining.
    assign w_issue    = (r_state == DRAIN) && !r_rd_all && !(r_skid_vld && !w_pop);
    assign w_shift    = w_issue && r_rd_vld && !(w_pop && !r_skid_vld);
    assign w_wr       = !reset && (r_state == FILL) && res_wr_en &&
                        ({1'b0, res_wr_addr} < (C_ADDR_BITS + 1)'(MN));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (res_done)   w_state_nxt = DRAIN;
            DRAIN:   if (w_last_pop) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[res_wr_addr] <= res_wr_data;
    end

    // The read register doubles as the output head; the skid holds the older beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data   <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_issue) r_rd_data   <= r_mem[r_rd_ptr];
            if (w_shift) r_skid_data <= r_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_last_pop) begin
            r_state     <= reset ? FILL : w_state_nxt;
            r_rd_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_rd_all    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_rd_vld  <= 1'b1;
                r_rd_last <= (r_rd_ptr == LAST_ADDR);
                if (r_rd_ptr == LAST_ADDR) r_rd_all <= 1'b1;
                else                       r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (w_pop && !r_skid_vld) begin
                r_rd_vld  <= 1'b0;
            end
            if (w_shift) begin
                r_skid_vld  <= 1'b1;
                r_skid_last <= r_rd_last;
            end else if (w_pop && r_skid_vld) begin
                r_skid_vld  <= 1'b0;
            end
            if (w_pop) r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign buffer_free = (r_state == FILL);
    assign AXIS_TVALID = r_skid_vld || r_rd_vld;
    assign AXIS_TDATA  = r_skid_vld ? r_skid_data : r_rd_data;
    assign AXIS_TLAST  = r_skid_vld ? r_skid_last : (r_rd_vld && r_rd_last);
endmodule

// File: tb/tb_output_mems.sv
// Bench for output_mems: fills the buffer, drains it under several TREADY patterns and
// compares every beat against an array model of the memory contents.
module tb_output_mems;
    localparam int OUTW = 28;
    localparam int MN   = 63;

    logic            clk = 1'b0;
    logic            reset;
    logic            res_wr_en;
    logic [5:0]      res_wr_addr;
    logic [OUTW-1:0] res_wr_data;
    logic            res_done;
    logic            buffer_free;
    logic [OUTW-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    output_mems #(.OUTW(OUTW), .M(7), .N(9)) dut (
        .clk(clk), .reset(reset),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
        .res_done(res_done), .buffer_free(buffer_free),
        .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TREADY(tready), .AXIS_TLAST(tlast)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] addr; logic [OUTW-1:0] data; bit with_done; } wvec_t;
    typedef struct { int idx; logic [OUTW-1:0] data; logic last; } bvec_t;

    int              total = 0;
    int              bad   = 0;
    logic [OUTW-1:0] exp_mem [MN];
    logic [OUTW-1:0] got [MN];
    bit              pat [6] = '{1, 0, 0, 1, 1, 0};
    wvec_t           wtab [5];
    bvec_t           btab [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [OUTW-1:0] d, input bit dn);
        res_wr_en = 1'b1; res_wr_addr = a; res_wr_data = d; res_done = dn;
        @(posedge clk); #1;
        res_wr_en = 1'b0; res_done = 1'b0;
    endtask

    task automatic pulse_done();
        res_done = 1'b1;
        @(posedge clk); #1;
        res_done = 1'b0;
    endtask

    // kind 0: 3*i-100, kind 1: random, kind 2: i+5000
    task automatic fill_all(input int kind);
        logic [OUTW-1:0] v;
        for (int i = 0; i < MN; i++) begin
            case (kind)
                0:       v = OUTW'(3 * i - 100);
                1:       v = OUTW'($urandom);
                default: v = OUTW'(i + 5000);
            endcase
            exp_mem[i] = v;
            wr(6'(i), v, 1'b0);
        end
    endtask

    // Called in the cycle after res_done. mode 0: TREADY=1, 1: pattern then random, 2: random.
    task automatic run_drain(input int mode, input int stop_after, input bit inject);
        int              c  = 0;
        int              nb = 0;
        bit              pv = 0;
        logic [OUTW-1:0] pd = '0;
        logic            pl = 1'b0;
        while (nb < MN && c < 2000) begin
            c++;
            case (mode)
                0:       tready = 1'b1;
                1:       tready = (c < 40) ? pat[(c - 1) % 6] : 1'($urandom_range(0, 1));
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (inject && c == 3) begin
                res_wr_en = 1'b1; res_wr_addr = 6'd5; res_wr_data = OUTW'(999); res_done = 1'b1;
            end else if (inject && c == 4) begin
                res_wr_en = 1'b0; res_done = 1'b0;
            end
            @(negedge clk);
            if (c == 1) begin
                check("free_in_drain", 32'(buffer_free), 32'd0);
                check("vld_before_read", 32'(tvalid), 32'd0);
            end
            if (c == 2 && mode == 0) check("first_vld_latency", 32'(tvalid), 32'd1);
            if (pv) begin
                check("stall_vld", 32'(tvalid), 32'd1);
                check("stall_data", 32'(tdata), 32'(pd));
                check("stall_last", 32'(tlast), 32'(pl));
            end
            if (tvalid) begin
                if (tready) begin
                    check("beat_data", 32'(tdata), 32'(exp_mem[nb]));
                    check("beat_last", 32'(tlast), 32'(nb == MN - 1));
                    got[nb] = tdata;
                    nb++;
                    pv = 0;
                    if (mode == 0) check("no_bubble", 32'(c), 32'(nb + 1));
                end else begin
                    pv = 1; pd = tdata; pl = tlast;
                end
            end
            @(posedge clk); #1;
            if (stop_after >= 0 && nb == stop_after + 1) break;
        end
        if (stop_after < 0) begin
            check("beat_count", 32'(nb), 32'(MN));
            check("free_after_drain", 32'(buffer_free), 32'd1);
            check("vld_after_drain", 32'(tvalid), 32'd0);
            check("last_after_drain", 32'(tlast), 32'd0);
        end else begin
            check("beats_before_abort", 32'(nb), 32'(stop_after + 1));
        end
    endtask

    initial begin
        wtab[0] = '{addr: 6'd0,  data: 28'h7FFFFFF, with_done: 1'b0};
        wtab[1] = '{addr: 6'd63, data: 28'd5,       with_done: 1'b0};
        wtab[2] = '{addr: 6'd10, data: 28'd11,      with_done: 1'b0};
        wtab[3] = '{addr: 6'd10, data: 28'd22,      with_done: 1'b0};
        wtab[4] = '{addr: 6'd62, data: 28'h8000000, with_done: 1'b1};
        btab[0] = '{idx: 0,  data: 28'h7FFFFFF, last: 1'b0};
        btab[1] = '{idx: 62, data: 28'h8000000, last: 1'b1};
        btab[2] = '{idx: 5,  data: 28'd5007,    last: 1'b0};
        btab[3] = '{idx: 10, data: 28'd22,      last: 1'b0};

        reset = 1'b1; res_wr_en = 1'b1; res_wr_addr = 6'd3; res_wr_data = 28'd77;
        res_done = 1'b0; tready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin reset = 1'b0; res_wr_en = 1'b0; end
            @(negedge clk);
            check("rst_vld", 32'(tvalid), 32'd0);
            check("rst_last", 32'(tlast), 32'd0);
            check("rst_data", 32'(tdata), 32'd0);
            check("rst_free", 32'(buffer_free), 32'd1);
            @(posedge clk); #1;
        end

        fill_all(0); pulse_done(); run_drain(0, -1, 0);
        fill_all(0); pulse_done(); run_drain(1, -1, 0);
        fill_all(1); pulse_done(); run_drain(2, -1, 0);

        for (int i = 0; i < MN; i++) begin
            exp_mem[i] = OUTW'(i * 1000 + 7);
            wr(6'(i), exp_mem[i], 1'b0);
        end
        foreach (wtab[k]) begin
            if (wtab[k].addr < 6'd63) exp_mem[wtab[k].addr] = wtab[k].data;
            wr(wtab[k].addr, wtab[k].data, wtab[k].with_done);
        end
        run_drain(0, -1, 1);
        foreach (btab[k]) begin
            check("bound_data", 32'(got[btab[k].idx]), 32'(btab[k].data));
            check("bound_last", 32'(btab[k].idx == MN - 1), 32'(btab[k].last));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_second_drain", 32'(tvalid), 32'd0);
            @(posedge clk); #1;
        end

        fill_all(1); pulse_done(); run_drain(0, 20, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_vld", 32'(tvalid), 32'd0);
        check("abort_free", 32'(buffer_free), 32'd1);
        fill_all(1); pulse_done(); run_drain(2, -1, 0);

        fill_all(2); pulse_done(); run_drain(0, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
